// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared types and tiling constants for the GEMM tile sequencer.
// Tile limits are derived from the small systolic array geometry.
package gemm_tile_sequencer_pkg;

  localparam int DIM_W          = 12;
  localparam int SMALL_SYS_ROWS = 8;
  localparam int SMALL_SYS_COLS = 8;
  // Both limits must stay <= 31 so that a tile size fits the 5-bit fields.
  localparam int MAX_TILE_K     = 2 * SMALL_SYS_ROWS;
  localparam int MAX_TILE_N     = 2 * SMALL_SYS_COLS;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic [4:0]       ksize;
    logic [4:0]       nsize;
    logic [DIM_W-1:0] k_base;
    logic [DIM_W-1:0] n_base;
    logic [DIM_W-1:0] m;
    logic             first_k;
    logic             last_k;
  } tile_desc_t;

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// Job-issue and tile-descriptor handshake bundle for the sequencer.
// The master is the sequencer; the slave is the front end plus the decoder.
interface gemm_tile_sequencer_if;
  import gemm_tile_sequencer_pkg::*;

  logic             job_valid;
  logic             job_ready;
  logic [DIM_W-1:0] m_dim;
  logic [DIM_W-1:0] k_dim;
  logic [DIM_W-1:0] n_dim;

  logic             tile_valid;
  logic             tile_ready;
  logic [4:0]       tile_ksize;
  logic [4:0]       tile_nsize;
  logic [DIM_W-1:0] tile_k_base;
  logic [DIM_W-1:0] tile_n_base;
  logic [DIM_W-1:0] tile_m;
  logic             tile_first_k;
  logic             tile_last_k;
  logic             job_done;

  modport master (
    input  job_valid, m_dim, k_dim, n_dim, tile_ready,
    output job_ready, tile_valid, tile_ksize, tile_nsize, tile_k_base,
           tile_n_base, tile_m, tile_first_k, tile_last_k, job_done
  );

  modport slave (
    output job_valid, m_dim, k_dim, n_dim, tile_ready,
    input  job_ready, tile_valid, tile_ksize, tile_nsize, tile_k_base,
           tile_n_base, tile_m, tile_first_k, tile_last_k, job_done
  );

endinterface

// File: rtl/gemm_tile_sequencer_tile_dim_clip.sv
// Clips the remaining extent of one dimension to the tile limit and flags
// the final tile along that dimension.
module tile_dim_clip
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int MAX_TILE = 16
) (
  input  logic [DIM_W-1:0] dim,
  input  logic [DIM_W-1:0] base,
  output logic [4:0]       size,
  output logic             last
);

  logic [DIM_W-1:0] remaining;
  logic [DIM_W:0]   base_plus_max;

  always_comb begin
    remaining     = dim - base;
    // One extra bit keeps base + MAX_TILE from wrapping near 2^DIM_W.
    base_plus_max = {1'b0, base} + (DIM_W + 1)'(MAX_TILE);
    size          = (remaining < DIM_W'(MAX_TILE)) ? remaining[4:0] : 5'(MAX_TILE);
    last          = (base_plus_max >= {1'b0, dim});
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Splits one (M x K) * (K x N) GEMM job into tile descriptors, N outer and
// K inner, so that accumulation runs over K within each N column.
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  gemm_tile_sequencer_if.master bus
);

  seq_state_e       state_q, state_d;
  logic [DIM_W-1:0] k_base_q, k_base_d;
  logic [DIM_W-1:0] n_base_q, n_base_d;
  logic [DIM_W-1:0] m_q, m_d;
  logic [DIM_W-1:0] k_dim_q, k_dim_d;
  logic [DIM_W-1:0] n_dim_q, n_dim_d;

  logic [4:0] ksize, nsize;
  logic       k_last, n_last;
  logic       job_ready, tile_valid, job_done;
  tile_desc_t desc;

  tile_dim_clip #(.MAX_TILE(MAX_TILE_K)) u_clip_k (
    .dim  (k_dim_q),
    .base (k_base_q),
    .size (ksize),
    .last (k_last)
  );

  tile_dim_clip #(.MAX_TILE(MAX_TILE_N)) u_clip_n (
    .dim  (n_dim_q),
    .base (n_base_q),
    .size (nsize),
    .last (n_last)
  );

  // NOTE: state registers use non-blocking assignments only; all next-state
  // math lives in always_comb so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_base_q <= '0;
      n_base_q <= '0;
      m_q      <= '0;
      k_dim_q  <= '0;
      n_dim_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_base_q <= k_base_d;
      n_base_q <= n_base_d;
      m_q      <= m_d;
      k_dim_q  <= k_dim_d;
      n_dim_q  <= n_dim_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // infer a latch.
  always_comb begin
    state_d    = state_q;
    k_base_d   = k_base_q;
    n_base_d   = n_base_q;
    m_d        = m_q;
    k_dim_d    = k_dim_q;
    n_dim_d    = n_dim_q;
    job_ready  = 1'b0;
    tile_valid = 1'b0;
    job_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (bus.job_valid) begin
          m_d      = bus.m_dim;
          k_dim_d  = bus.k_dim;
          n_dim_d  = bus.n_dim;
          k_base_d = '0;
          n_base_d = '0;
          // An empty job skips emission but still reports completion.
          if (bus.m_dim == '0 || bus.k_dim == '0 || bus.n_dim == '0) begin
            state_d = DONE;
          end else begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        tile_valid = 1'b1;
        if (bus.tile_ready) begin
          if (!k_last) begin
            k_base_d = k_base_q + DIM_W'(MAX_TILE_K);
          end else begin
            k_base_d = '0;
            n_base_d = n_base_q + DIM_W'(MAX_TILE_N);
            if (n_last) state_d = DONE;
          end
        end
      end
      DONE: begin
        job_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Descriptor reads as all-zero outside EMIT so idle outputs stay quiet.
  always_comb begin
    desc = '0;
    if (state_q == EMIT) begin
      desc.ksize   = ksize;
      desc.nsize   = nsize;
      desc.k_base  = k_base_q;
      desc.n_base  = n_base_q;
      desc.m       = m_q;
      desc.first_k = (k_base_q == '0);
      desc.last_k  = k_last;
    end
  end

  assign bus.job_ready    = job_ready;
  assign bus.tile_valid   = tile_valid;
  assign bus.job_done     = job_done;
  assign bus.tile_ksize   = desc.ksize;
  assign bus.tile_nsize   = desc.nsize;
  assign bus.tile_k_base  = desc.k_base;
  assign bus.tile_n_base  = desc.n_base;
  assign bus.tile_m       = desc.m;
  assign bus.tile_first_k = desc.first_k;
  assign bus.tile_last_k  = desc.last_k;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer with MAX_TILE_K = MAX_TILE_N = 16.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_gemm_tile_sequencer;
  import gemm_tile_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  gemm_tile_sequencer_if bus ();

  gemm_tile_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] obs_desc();
    return {15'd0, bus.tile_valid, bus.tile_ksize, bus.tile_nsize, bus.tile_k_base,
            bus.tile_n_base, bus.tile_m, bus.tile_first_k, bus.tile_last_k};
  endfunction

  function automatic logic [63:0] exp_desc(input int ks, input int ns, input int kb,
                                           input int nb, input int m,
                                           input logic first, input logic last);
    return {15'd0, 1'b1, 5'(ks), 5'(ns), 12'(kb), 12'(nb), 12'(m), first, last};
  endfunction

  // {job_ready, tile_valid, job_done}
  function automatic logic [63:0] obs_ctl();
    return {61'd0, bus.job_ready, bus.tile_valid, bus.job_done};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents a job for exactly one edge; dims are scrambled afterwards so the
  // bench notices if the DUT fails to latch them.
  task automatic start_job(input int m, input int k, input int n);
    check("accept_ready", obs_ctl(), 64'b100);
    bus.job_valid = 1'b1;
    bus.m_dim     = 12'(m);
    bus.k_dim     = 12'(k);
    bus.n_dim     = 12'(n);
    step();
    bus.job_valid = 1'b0;
    bus.m_dim     = 12'hABC;
    bus.k_dim     = 12'h5A5;
    bus.n_dim     = 12'h3C3;
  endtask

  initial begin
    int kb;
    int nb;
    int ks;
    int ns;
    int tiles;
    logic done_seen;

    rst            = 1'b1;
    bus.job_valid  = 1'b0;
    bus.tile_ready = 1'b1;
    bus.m_dim      = '0;
    bus.k_dim      = '0;
    bus.n_dim      = '0;
    @(negedge clk);
    step();
    check("reset_ctl", obs_ctl(), 64'b100);
    check("reset_desc", obs_desc(), 64'd0);
    rst = 1'b0;
    step();
    check("idle_ctl", obs_ctl(), 64'b100);

    // 1: K=20, N=10, M=8
    start_job(8, 20, 10);
    check("t1_tile0", obs_desc(), exp_desc(16, 10, 0, 0, 8, 1'b1, 1'b0));
    step();
    check("t1_tile1", obs_desc(), exp_desc(4, 10, 16, 0, 8, 1'b0, 1'b1));
    step();
    check("t1_done", obs_ctl(), 64'b001);
    step();
    check("t1_idle", obs_ctl(), 64'b100);

    // 2: K=16, N=40, M=3
    start_job(3, 16, 40);
    check("t2_tile0", obs_desc(), exp_desc(16, 16, 0, 0, 3, 1'b1, 1'b1));
    step();
    check("t2_tile1", obs_desc(), exp_desc(16, 16, 0, 16, 3, 1'b1, 1'b1));
    step();
    check("t2_tile2", obs_desc(), exp_desc(16, 8, 0, 32, 3, 1'b1, 1'b1));
    step();
    check("t2_done", obs_ctl(), 64'b001);
    step();

    // 3: K=8, N=8, M=5 with back-pressure
    bus.tile_ready = 1'b0;
    start_job(5, 8, 8);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall", obs_desc(), exp_desc(8, 8, 0, 0, 5, 1'b1, 1'b1));
      step();
    end
    bus.tile_ready = 1'b1;
    check("t3_release", obs_desc(), exp_desc(8, 8, 0, 0, 5, 1'b1, 1'b1));
    step();
    check("t3_done", obs_ctl(), 64'b001);
    step();

    // 4: K=0 -> no tiles, straight to completion
    start_job(2, 0, 12);
    check("t4_done", obs_ctl(), 64'b001);
    step();
    check("t4_idle", obs_ctl(), 64'b100);

    // 5: K=48, N=32, reset after three tiles
    start_job(4, 48, 32);
    check("t5_tile0", obs_desc(), exp_desc(16, 16, 0, 0, 4, 1'b1, 1'b0));
    step();
    check("t5_tile1", obs_desc(), exp_desc(16, 16, 16, 0, 4, 1'b0, 1'b0));
    step();
    check("t5_tile2", obs_desc(), exp_desc(16, 16, 32, 0, 4, 1'b0, 1'b1));
    step();
    check("t5_tile3", obs_desc(), exp_desc(16, 16, 0, 16, 4, 1'b1, 1'b0));
    rst = 1'b1;
    step();
    check("t5_rst_ctl", obs_ctl(), 64'b100);
    check("t5_rst_desc", obs_desc(), 64'd0);
    rst = 1'b0;
    step();
    check("t5_no_done", obs_ctl(), 64'b100);
    start_job(1, 4, 4);
    check("t5_new_tile", obs_desc(), exp_desc(4, 4, 0, 0, 1, 1'b1, 1'b1));
    step();
    check("t5_new_done", obs_ctl(), 64'b001);
    step();

    // 6: K=4095, N=17 -> 256 K tiles x 2 N columns
    start_job(7, 4095, 17);
    kb = 0;
    nb = 0;
    tiles = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
      if (bus.tile_valid) begin
        ks = (4095 - kb < 16) ? 4095 - kb : 16;
        ns = (17 - nb < 16) ? 17 - nb : 16;
        check("t6_tile", obs_desc(), exp_desc(ks, ns, kb, nb, 7, kb == 0, kb + 16 >= 4095));
        tiles++;
        if (kb + 16 >= 4095) begin
          kb = 0;
          nb += 16;
        end else begin
          kb += 16;
        end
        step();
      end else begin
        done_seen = bus.job_done;
        if (!done_seen) step();
      end
    end
    check("t6_done_seen", 64'(done_seen), 64'd1);
    check("t6_tile_count", 64'(tiles), 64'd512);
    step();
    check("t6_idle", obs_ctl(), 64'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
